nbit_serial_addsub: RTL and testbench
=====================================

// Module: nbit_serial_addsub
// PURPOSE
//  Parametrised digit-serial adder/subtractor for the ALU datapath.
//  Processes Digit bits per clock, so Width-bit results take Width/Digit cycles.
//  Mode selects add or subtract. A start/busy/done handshake lets the ALU
//  sequencer trade latency for area. Produces carry/borrow, signed overflow and
//  zero flags alongside the result.
// PARAMETERS
//  Width  16  operand/result width in bits; must be >= 1
//  Digit   4  bits processed per cycle; 1 <= Digit <= Width, Width % Digit == 0
//  (derived) N = Width/Digit = cycles per operation
// PORTS
//  clk     in   1      rising-edge clock; single clock domain
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when busy==0
//  Mode    in   1      0 = add, 1 = subtract; latched with start
//  A       in   Width  minuend/augend; latched with start
//  B       in   Width  subtrahend/addend; latched with start
//  Cin     in   1      carry-in (add) or borrow-in (sub); latched with start
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse: D and flags just updated
//  D       out  Width  result; holds until next completion
//  Cout    out  1      add: carry out; sub: borrow out (1 when A < B+Cin unsigned)
//  Ovflow  out  1      two's-complement signed overflow of result
//  Zero    out  1      1 when D == 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; busy, done, D, Cout, Ovflow, Zero = 0;
//    internal shift registers and digit counter cleared. Takes effect
//    immediately, including mid-operation. An aborted op never produces done.
//  - FSM: IDLE -> BUSY on start. BUSY stays for N cycles, then -> DONE.
//    DONE -> IDLE after one cycle, or -> BUSY if start is seen in the DONE cycle.
//    busy = (state==BUSY). done = (state==DONE).
//  - Timing: start sampled at edge k with busy==0. busy=1 from k to k+N.
//    At edge k+N, D, Cout, Ovflow and Zero update together; busy->0, done->1.
//    done clears at edge k+N+1 unless a new op completes.
//    Latency is N cycles from start to done.
//  - start while busy==1 is ignored. The in-flight op and its latched operands
//    are unaffected. Inputs may change freely after the start edge.
//  - Arithmetic: sub is computed as A + ~B + ~Cin; borrow = ~carry.
//    Add is A + B + Cin. All arithmetic is modulo 2^Width.
//  - Each BUSY cycle consumes the lowest remaining Digit bits, LSB digit first.
//  - The inter-digit carry register is initialised from Cin (add) or ~Cin (sub).
//  - Ovflow = carry into MSB XOR carry out of MSB, taken from the final digit.
//  - D updates only at completion; partial sums are never visible on D.
//  - Digit==Width is legal (N=1, one BUSY cycle). Width==1 is legal.
// TESTING  (Width=16, Digit=4, N=4 unless noted)
//  1. sub A=0x0005 B=0x0003 Cin=0 -> D=0x0002 Cout=0 Ovflow=0 Zero=0;
//     done exactly 4 cycles after start, busy high those 4 cycles.
//  2. sub A=0x0003 B=0x0005 Cin=0 -> D=0xFFFE Cout=1;
//     sub A=0x8000 B=0x0001 -> D=0x7FFF Ovflow=1 Cout=0.
//  3. add A=0xFFFF B=0x0001 Cin=0 -> D=0x0000 Cout=1 Zero=1 Ovflow=0;
//     add A=0x7FFF B=0x0000 Cin=1 -> D=0x8000 Ovflow=1.
//  4. start pulsed again mid-BUSY with other operands -> ignored, first result
//     returned; start during DONE cycle -> next op done 4 cycles later, no gap.
//  5. rst_n low at cycle 2 of BUSY -> busy, done, D and flags 0 immediately;
//     no done pulse; next start after release completes normally.
//  6. Exhaustive for Width=4 with Digit=1,2,4: all A, B, Cin, Mode vs behavioural
//     model {Cout,D} and Ovflow; zero mismatches.

Source files
------------

// File: rtl/nbit_serial_addsub.sv
// ---------------------------------------------------------------------------
// nbit_serial_addsub
//   Digit-serial adder/subtractor. Each busy cycle adds the lowest remaining
//   Digit bits of the latched operands, LSB digit first, so a Width-bit
//   result takes N = Width/Digit cycles. Subtraction is A + ~B + ~Cin, and
//   the reported borrow is the inverse of the final carry.
//
// Parameters
//   Width  operand/result width (>= 1)
//   Digit  bits per cycle (1 <= Digit <= Width, Width % Digit == 0)
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request, sampled only while busy == 0
//   Mode    in   0 = add, 1 = subtract (latched with start)
//   A, B    in   operands (latched with start)
//   Cin     in   carry-in (add) / borrow-in (sub) (latched with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse, D and flags just updated
//   D       out  result, held until the next completion
//   Cout    out  add: carry out; sub: borrow out
//   Ovflow  out  two's-complement overflow
//   Zero    out  D == 0
// ---------------------------------------------------------------------------
module nbit_serial_addsub #(
  parameter int Width = 16,
  parameter int Digit = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Mode,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] D,
  output logic             Cout,
  output logic             Ovflow,
  output logic             Zero
);

  localparam int N      = Width / Digit;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W  = Digit + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] a_q, b_q, res_q;
  logic             carry_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [Width-1:0] d_q;
  logic             cout_q, ovf_q, zero_q;

  logic             accept;
  logic             last_digit;
  logic [SUM_W-1:0] dig_sum;
  logic             msb_cin;
  logic [Width-1:0] res_next;

  // A new request is taken whenever no operation is in flight, which
  // includes the DONE cycle so back-to-back operations have no gap.
  assign accept     = start && (state_q != S_BUSY);
  assign last_digit = (state_q == S_BUSY) && (cnt_q == LAST_CNT);

  // One digit of the ripple add; B is already inverted for subtract.
  assign dig_sum = {1'b0, a_q[Digit-1:0]} + {1'b0, b_q[Digit-1:0]} + SUM_W'(carry_q);

  // Carry into the digit's MSB recovered from the sum bit: s = a ^ b ^ cin.
  assign msb_cin = dig_sum[Digit-1] ^ a_q[Digit-1] ^ b_q[Digit-1];

  // Result assembles from the top down: each new digit enters at the MSB
  // end, so after N digits the first digit has reached bit 0.
  assign res_next = (res_q >> Digit) | (Width'(dig_sum[Digit-1:0]) << (Width - Digit));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_BUSY : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= Mode ? ~B : B;
      carry_q <= Mode ? ~Cin : Cin;
      mode_q  <= Mode;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_BUSY) begin
      a_q     <= a_q >> Digit;
      b_q     <= b_q >> Digit;
      carry_q <= dig_sum[Digit];
      res_q   <= res_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_digit) begin
        d_q    <= res_next;
        cout_q <= mode_q ? ~dig_sum[Digit] : dig_sum[Digit];
        ovf_q  <= msb_cin ^ dig_sum[Digit];
        zero_q <= (res_next == '0);
      end
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign D      = d_q;
  assign Cout   = cout_q;
  assign Ovflow = ovf_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_nbit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_nbit_serial_addsub
//   Self-checking bench: a 16/4 instance for directed, handshake, reset and
//   random tests, plus three 4-bit instances (Digit = 1, 2, 4) driven in
//   parallel for an exhaustive sweep against an integer reference model.
// ---------------------------------------------------------------------------
module tb_nbit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf, zero;
  logic [15:0] d;

  logic        sm_start = 1'b0;
  logic        sm_mode = 1'b0;
  logic [3:0]  sm_a = '0;
  logic [3:0]  sm_b = '0;
  logic        sm_cin = 1'b0;
  logic        sm_busy [3];
  logic        sm_done [3];
  logic [3:0]  sm_d    [3];
  logic        sm_cout [3];
  logic        sm_ovf  [3];
  logic        sm_zero [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nbit_serial_addsub #(.Width(16), .Digit(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Mode(mode), .A(a), .B(b), .Cin(cin),
    .busy(busy), .done(done), .D(d), .Cout(cout), .Ovflow(ovf), .Zero(zero)
  );

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_small
      nbit_serial_addsub #(.Width(4), .Digit(1 << gi)) u_sm (
        .clk(clk), .rst_n(rst_n), .start(sm_start), .Mode(sm_mode), .A(sm_a), .B(sm_b),
        .Cin(sm_cin), .busy(sm_busy[gi]), .done(sm_done[gi]), .D(sm_d[gi]),
        .Cout(sm_cout[gi]), .Ovflow(sm_ovf[gi]), .Zero(sm_zero[gi])
      );
    end
  endgenerate

  // Reference: plain integer arithmetic. Returns {zero, ovf, cout, d[15:0]}.
  function automatic logic [18:0] ref_model(input int w, input bit m, input longint av,
                                             input longint bv, input bit c);
    longint full, half, mask, u, sa, sb, s;
    logic   co, ov;
    logic [15:0] dv;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    mask = full - 1;
    sa   = (av >= half) ? av - full : av;
    sb   = (bv >= half) ? bv - full : bv;
    if (!m) begin
      u  = av + bv + longint'(c);
      co = (u > mask);
      s  = sa + sb + longint'(c);
    end else begin
      u  = av - bv - longint'(c);
      co = (av < bv + longint'(c));
      s  = sa - sb - longint'(c);
    end
    ov = (s > half - 1) || (s < -half);
    dv = 16'(u & mask);
    return {(dv == 16'd0), ov, co, dv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Start one op on the 16-bit instance, scramble inputs afterwards, wait
  // (bounded) for done and check latency, busy duration and result.
  task automatic run_main(input bit m, input logic [15:0] av, input logic [15:0] bv,
                          input bit c, input string tag);
    int cyc;
    int busy_cnt;
    logic [18:0] expv;
    expv = ref_model(16, m, longint'(av), longint'(bv), c);
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv; cin = c;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); mode = 1'($urandom);
    cyc = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 32'(cyc - 1), 32'd4);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, " result"}, {13'd0, zero, ovf, cout, d}, {13'd0, expv});
    $display("[TB] %s mode=%0d A=%h B=%h Cin=%0d -> D=%h Cout=%0d Ovf=%0d Zero=%0d",
             tag, m, av, bv, c, d, cout, ovf, zero);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    logic [18:0] expv;
    logic [18:0] exps;

    // Reset state
    #2;
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset D/flags", {13'd0, zero, ovf, cout, d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases with literal expectations
    run_main(1'b1, 16'h0005, 16'h0003, 1'b0, "t1_sub");
    check("t1 D/flags", {13'd0, zero, ovf, cout, d}, {13'd0, 3'b000, 16'h0002});
    run_main(1'b1, 16'h0003, 16'h0005, 1'b0, "t2_sub_neg");
    check("t2a D/Cout", {15'd0, cout, d}, {15'd0, 1'b1, 16'hFFFE});
    run_main(1'b1, 16'h8000, 16'h0001, 1'b0, "t2_sub_ovf");
    check("t2b D/Ovf/Cout", {14'd0, ovf, cout, d}, {14'd0, 2'b10, 16'h7FFF});
    run_main(1'b0, 16'hFFFF, 16'h0001, 1'b0, "t3_add_wrap");
    check("t3a D/flags", {13'd0, zero, ovf, cout, d}, {13'd0, 3'b101, 16'h0000});
    run_main(1'b0, 16'h7FFF, 16'h0000, 1'b1, "t3_add_ovf");
    check("t3b D/Ovf", {15'd0, ovf, d}, {15'd0, 1'b1, 16'h8000});

    // start mid-BUSY is ignored
    expv = ref_model(16, 1'b0, 64'h1234, 64'h0F0F, 1'b1);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h0F0F; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4a latency", 32'(cyc - 1), 32'd4);
    check("t4a result", {13'd0, zero, ovf, cout, d}, {13'd0, expv});
    $display("[TB] t4a mid-busy start ignored -> D=%h", d);

    // start during the DONE cycle: next op follows with no idle gap
    start = 1'b1; mode = 1'b1; a = 16'h0100; b = 16'h0001; cin = 1'b1;
    expv = ref_model(16, 1'b1, 64'h0100, 64'h0001, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check("t4b busy after done-cycle start", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4b latency", 32'(cyc - 1), 32'd4);
    check("t4b result", {13'd0, zero, ovf, cout, d}, {13'd0, expv});
    $display("[TB] t4b back-to-back -> D=%h", d);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 busy/done in reset", {30'd0, busy, done}, 32'd0);
    check("t5 D/flags in reset", {13'd0, zero, ovf, cout, d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("t5 no done after abort", 32'(done_cnt), 32'd0);
    $display("[TB] t5 reset mid-op, no done pulse seen=%0d", done_cnt);
    run_main(1'b1, 16'h4000, 16'h0123, 1'b1, "t5_after_reset");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      run_main(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
               $sformatf("rand%0d", i));
    end

    // Exhaustive 4-bit sweep, Digit = 1, 2, 4 in parallel
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        for (int av = 0; av < 16; av++) begin
          for (int bv = 0; bv < 16; bv++) begin
            @(negedge clk);
            sm_start = 1'b1; sm_mode = 1'(m); sm_cin = 1'(c); sm_a = 4'(av); sm_b = 4'(bv);
            @(negedge clk);
            sm_start = 1'b0;
            repeat (5) @(negedge clk);
            exps = ref_model(4, 1'(m), longint'(av), longint'(bv), 1'(c));
            for (int k = 0; k < 3; k++) begin
              check($sformatf("exh Digit=%0d m=%0d c=%0d A=%0h B=%0h", 1 << k, m, c, av, bv),
                    {25'd0, sm_zero[k], sm_ovf[k], sm_cout[k], sm_d[k]},
                    {25'd0, exps[18:16], exps[3:0]});
            end
          end
        end
        $display("[TB] exhaustive block mode=%0d cin=%0d done", m, c);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
